// File: rtl/mod_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : mod_updown_counter_if
// Description : Control/status bundle for mod_updown_counter.
//               master modport : drives en, load, load_val, up, sat, clr_ovf;
//                                observes count, tc, ovf.
//               slave modport  : the counter side of the same signals.
// Ports       : en, load, load_val[WIDTH-1:0], up, sat, clr_ovf (to counter)
//               count[WIDTH-1:0], tc, ovf                      (from counter)
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             up;
   logic             sat;
   logic             clr_ovf;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (
      output en, load, load_val, up, sat, clr_ovf,
      input  count, tc, ovf
   );

   modport slave (
      input  en, load, load_val, up, sat, clr_ovf,
      output count, tc, ovf
   );
endinterface
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_updown_counter
// Description : Parametrised modulo up/down counter with direction control,
//               wrap/saturate mode, synchronous load, registered
//               terminal-count pulse and sticky overflow flag.
//               Optional enable prescaler, compiled in with the macro
//               COUNTER_PRESCALE_EN (PRESCALE en-cycles per count step).
// Ports       : clk   - clock, rising edge
//               arstn - asynchronous active-low reset
//               bus   - mod_updown_counter_if.slave
//                       en, load, load_val, up, sat, clr_ovf in;
//                       count, tc, ovf out (all registered)
// Parameters  : WIDTH (2..32), MODULUS (2..2**WIDTH), RESET_VAL (<MODULUS),
//               PRESCALE (>=1, used only with COUNTER_PRESCALE_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
   parameter int     WIDTH     = 8,
   parameter longint MODULUS   = 256,
   parameter longint RESET_VAL = 0,
   parameter int     PRESCALE  = 4
) (
   input  wire logic               clk,
   input  wire logic               arstn,
   mod_updown_counter_if.slave     bus
);

   localparam logic [WIDTH-1:0] c_max   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);

   // Elaboration-time parameter sanity checks.
   generate
      if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
         $error("mod_updown_counter: WIDTH out of range");
      end
      if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
         $error("mod_updown_counter: MODULUS out of range");
      end
      if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
         $error("mod_updown_counter: RESET_VAL must be below MODULUS");
      end
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("mod_updown_counter: PRESCALE must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;

   logic             w_step;
   logic             w_boundary;
   logic             w_event;
   logic [WIDTH-1:0] w_load_clamped;
   logic [WIDTH-1:0] w_count_nxt;

`ifdef COUNTER_PRESCALE_EN
   localparam int               c_pw      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [c_pw-1:0]  c_pre_max = c_pw'(PRESCALE - 1);

   logic [c_pw-1:0] r_pre;
   logic            w_pre_tc;

   assign w_pre_tc = (r_pre == c_pre_max);
   assign w_step   = bus.en & w_pre_tc;

   // Counts en-cycles only; the stepping cycle returns it to zero so the
   // period is exactly PRESCALE enabled cycles regardless of en gaps.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_pre <= '0;
      end else if (bus.load) begin
         r_pre <= '0;
      end else if (bus.en) begin
         r_pre <= w_pre_tc ? '0 : r_pre + 1'b1;
      end
   end
`else
   assign w_step = bus.en;
`endif

   // A load never clamps when MODULUS == 2**WIDTH since c_max is all ones.
   assign w_load_clamped = (bus.load_val > c_max) ? c_max : bus.load_val;

   assign w_boundary = bus.up ? (r_count == c_max) : (r_count == '0);
   assign w_event    = ~bus.load & w_step & w_boundary;

   // Explicit compare-and-wrap keeps arithmetic modulo MODULUS even when it
   // is not a power of two.
   always_comb begin
      w_count_nxt = r_count;
      if (w_boundary) begin
         if (!bus.sat) begin
            w_count_nxt = bus.up ? '0 : c_max;
         end
      end else begin
         w_count_nxt = bus.up ? r_count + 1'b1 : r_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_count <= c_reset;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (bus.load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
         end else if (w_step) begin
            r_count <= w_count_nxt;
            r_tc    <= w_boundary;
         end else begin
            r_tc    <= 1'b0;
         end
         // Set has priority over clear on the same edge.
         r_ovf <= w_event | (r_ovf & ~bus.clr_ovf);
      end
   end

   assign bus.count = r_count;
   assign bus.tc    = r_tc;
   assign bus.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_updown_counter
// Description : Self-checking bench. Two counters share one stimulus stream:
//               index 0 = default parameters (MODULUS 256, RESET_VAL 0),
//               index 1 = WIDTH 4, MODULUS 10, RESET_VAL 3.
//               A behavioural model predicts count/tc/ovf every cycle;
//               directed sequences pin the model with literal values.
//               Honours COUNTER_PRESCALE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

`ifdef COUNTER_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic       clk;
   logic       arstn;
   logic       en, load, up, sat, clr_ovf;
   logic [7:0] load_val;

   int checks = 0;
   int errors = 0;

   mod_updown_counter_if #(.WIDTH(8)) ifa ();
   mod_updown_counter_if #(.WIDTH(4)) ifb ();

   assign ifa.en = en;  assign ifa.load = load;  assign ifa.load_val = load_val;
   assign ifa.up = up;  assign ifa.sat = sat;    assign ifa.clr_ovf = clr_ovf;
   assign ifb.en = en;  assign ifb.load = load;  assign ifb.load_val = load_val[3:0];
   assign ifb.up = up;  assign ifb.sat = sat;    assign ifb.clr_ovf = clr_ovf;

   mod_updown_counter #(.WIDTH(8), .MODULUS(256), .RESET_VAL(0), .PRESCALE(4)) u_dut_a (
      .clk(clk), .arstn(arstn), .bus(ifa.slave));
   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3), .PRESCALE(4)) u_dut_b (
      .clk(clk), .arstn(arstn), .bus(ifb.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   longint m_mod [2] = '{256, 10};
   longint m_rst [2] = '{0, 3};
   longint m_cnt [2];
   bit     m_tc  [2];
   bit     m_ovf [2];
   int     m_pre [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = m_rst[i]; m_tc[i] = 0; m_ovf[i] = 0; m_pre[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         longint lv   = (i == 0) ? longint'(load_val) : longint'(load_val & 8'h0f);
         bit     step = en;
         bit     evt  = 0;
         if (load) m_pre[i] = 0;
         else if (en) begin
            step     = (m_pre[i] == PS - 1);
            m_pre[i] = (m_pre[i] + 1) % PS;
         end
         if (load) begin
            m_cnt[i] = (lv < m_mod[i]) ? lv : m_mod[i] - 1;
            m_tc[i]  = 0;
         end else if (step) begin
            evt = up ? (m_cnt[i] == m_mod[i] - 1) : (m_cnt[i] == 0);
            m_tc[i] = evt;
            if (!(evt && sat))
               m_cnt[i] = (m_cnt[i] + (up ? 1 : m_mod[i] - 1)) % m_mod[i];
         end else begin
            m_tc[i] = 0;
         end
         if (evt) m_ovf[i] = 1;
         else if (clr_ovf) m_ovf[i] = 0;
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("a.count", 64'(ifa.count), 64'(m_cnt[0]));
      chk("a.tc",    64'(ifa.tc),    64'(m_tc[0]));
      chk("a.ovf",   64'(ifa.ovf),   64'(m_ovf[0]));
      chk("b.count", 64'(ifb.count), 64'(m_cnt[1]));
      chk("b.tc",    64'(ifb.tc),    64'(m_tc[1]));
      chk("b.ovf",   64'(ifb.ovf),   64'(m_ovf[1]));
   endtask

   // One clock: model advances with the inputs in force, DUT is sampled #1
   // after the edge and compared.
   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic idle();
      en = 0; load = 0; clr_ovf = 0;
   endtask

   task automatic do_load(input logic [7:0] v);
      load = 1; load_val = v; cycle(); load = 0;
   endtask

   initial begin
      arstn = 0; idle(); up = 1; sat = 0; load_val = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      chk("reset a.count", 64'(ifa.count), 64'd0);
      chk("reset b.count", 64'(ifb.count), 64'd3);
      @(negedge clk);
      arstn = 1;
      @(posedge clk); #1;

      // Free run up with wrap over the full 256 range.
      en = 1; up = 1; sat = 0;
      cycles(255 * PS);
      chk("wrap a.count pre", 64'(ifa.count), 64'd255);
      chk("wrap a.tc pre",    64'(ifa.tc),    64'd0);
      cycles(PS);
      chk("wrap a.count", 64'(ifa.count), 64'd0);
      chk("wrap a.tc",    64'(ifa.tc),    64'd1);
      chk("wrap a.ovf",   64'(ifa.ovf),   64'd1);
      cycles(PS);
      chk("wrap a.tc after", 64'(ifa.tc), 64'd0);

      // Modulo-10 count down with wrap, and load clamping.
      idle(); do_load(8'd7);
      chk("load7 b.count", 64'(ifb.count), 64'd7);
      en = 1; up = 0;
      cycles(7 * PS);
      chk("down b.count 0", 64'(ifb.count), 64'd0);
      cycles(PS);
      chk("down b.count 9", 64'(ifb.count), 64'd9);
      chk("down b.tc",      64'(ifb.tc),    64'd1);
      cycles(PS);
      chk("down b.count 8", 64'(ifb.count), 64'd8);
      idle(); do_load(8'd12);
      chk("clamp b.count", 64'(ifb.count), 64'd9);

      // Saturation at the top.
      sat = 1; up = 1; do_load(8'd8);
      en = 1;
      for (int s = 0; s < 4; s++) begin
         cycles(PS);
         chk("sat b.count", 64'(ifb.count), 64'd9);
         chk("sat b.tc",    64'(ifb.tc),    (s == 0) ? 64'd0 : 64'd1);
      end
      up = 0; cycles(PS);
      chk("sat down b.count", 64'(ifb.count), 64'd8);
      chk("sat down b.tc",    64'(ifb.tc),    64'd0);

      // ovf set-wins and clear.
      idle(); clr_ovf = 1; cycle(); clr_ovf = 0;
      chk("clr b.ovf", 64'(ifb.ovf), 64'd0);
      up = 1; do_load(8'd9);
      en = 1; clr_ovf = 1; cycles(PS);
      chk("setwins b.ovf", 64'(ifb.ovf), 64'd1);
      idle(); clr_ovf = 1; cycle(); clr_ovf = 0;
      chk("clr2 b.ovf", 64'(ifb.ovf), 64'd0);
      en = 1; load = 1; load_val = 8'd5; cycle(); load = 0;
      chk("loadwins b.count", 64'(ifb.count), 64'd5);

      // Asynchronous reset between edges.
      sat = 0; up = 1; en = 1; cycles(3 * PS + 1);
      #2 arstn = 0;
      #1;
      model_reset();
      chk("areset b.count", 64'(ifb.count), 64'd3);
      chk("areset b.tc",    64'(ifb.tc),    64'd0);
      chk("areset b.ovf",   64'(ifb.ovf),   64'd0);
      chk("areset a.count", 64'(ifa.count), 64'd0);
      #1 arstn = 1;
      cycles(PS);
      chk("resume b.count", 64'(ifb.count), 64'd4);

`ifdef COUNTER_PRESCALE_EN
      idle(); do_load(8'd0);
      en = 1; cycles(3);
      chk("ps b.count 3clk", 64'(ifb.count), 64'd0);
      cycle();
      chk("ps b.count 4clk", 64'(ifb.count), 64'd1);
      cycles(2); en = 0; cycles(2); en = 1; cycle();
      chk("ps b.count 5clk", 64'(ifb.count), 64'd1);
      cycle();
      chk("ps b.count 6clk", 64'(ifb.count), 64'd2);
`endif

      // Randomised traffic.
      for (int r = 0; r < 3000; r++) begin
         en       = ($urandom_range(0, 9) < 8);
         load     = ($urandom_range(0, 39) == 0);
         load_val = 8'($urandom);
         if ($urandom_range(0, 7) == 0) up  = ~up;
         if ($urandom_range(0, 15) == 0) sat = ~sat;
         clr_ovf  = ($urandom_range(0, 19) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
